fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the fifo block between NREQ producers using round-robin bursts.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (ARB = searching, OWN = a producer holds the port)
//   BURST_W     : width of the per-grant beat counter
//   IDLE_W      : width of the idle (valid-low) counter used for grant timeout
package fifo_arb_pkg;

  typedef enum logic {ARB, OWN} arb_state_t;

  localparam int BURST_W = 4;
  localparam int IDLE_W  = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting one past 'last' and wrapping modulo NREQ; the first
// asserted bit wins.
//   req    in  NREQ  request vector
//   last   in  IDXW  index of the most recent winner
//   onehot out NREQ  one-hot winner (0 when nothing requests)
//   idx    out IDXW  winner index (0 when nothing requests)
//   hit    out 1     at least one request was found
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] onehot,
  output logic [IDXW-1:0] idx,
  output logic            hit
);

  always_comb begin
    int cand;
    onehot = '0;
    idx    = '0;
    hit    = 1'b0;
    cand   = 0;
    // k=NREQ wraps back to 'last' itself, so a lone previous winner still wins.
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!hit && req[cand]) begin
        hit          = 1'b1;
        idx          = IDXW'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the single FIFO write port.
// A producer keeps the port for a whole burst (until req_last, MAX_BURST
// beats, or TIMEOUT idle cycles) so its words land contiguously in the FIFO.
// A FIFO read in the same cycle drops a write, so reads block writes here.
//   clk, rst_n     clock and asynchronous active-low reset
//   req_valid      per-requester word valid
//   req_data       packed words, requester i at [i*DWIDTH +: DWIDTH]
//   req_last       per-requester last-word-of-burst flag
//   req_ready      word accepted this cycle (only the owner's bit can be set)
//   grant          registered one-hot owner, 0 when nobody owns the port
//   fifo_write_en  FIFO write enable
//   fifo_data_in   FIFO write data (0 when nobody owns the port)
//   fifo_full      FIFO full flag
//   fifo_empty     FIFO empty flag
//   fifo_read_en   copy of the FIFO read enable (observed only)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        grant,
  output logic                   fifo_write_en,
  output logic [DWIDTH-1:0]      fifo_data_in,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  input  logic                   fifo_read_en
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t          state;
  logic [IDXW-1:0]     rr_last;
  logic [BURST_W-1:0]  burst_cnt;
  logic [IDLE_W-1:0]   idle_cnt;

  logic [NREQ-1:0]     pick_onehot;
  logic [IDXW-1:0]     pick_idx;
  logic                pick_hit;

  logic                owned;
  logic                owner_valid;
  logic                owner_last;
  logic [DWIDTH-1:0]   owner_data;
  logic                can_wr;
  logic [BURST_W-1:0]  burst_next;
  logic [IDLE_W-1:0]   idle_next;
  logic                last_beat;
  logic                timeout_hit;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req    (req_valid),
    .last   (rr_last),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .hit    (pick_hit)
  );

  // While in OWN the owner is always rr_last, since the winner is recorded
  // there at grant time.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDXW'(i) == rr_last) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign owned         = (state == OWN);
  // A read on a non-empty FIFO wins the port and would drop our write.
  assign can_wr        = !fifo_full && !(fifo_read_en && !fifo_empty);
  assign fifo_write_en = owned && owner_valid && can_wr;
  assign fifo_data_in  = owned ? owner_data : '0;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDXW'(i) == rr_last) req_ready[i] = fifo_write_en;
    end
  end

  assign burst_next  = burst_cnt + 1'b1;
  assign idle_next   = idle_cnt + 1'b1;
  assign last_beat   = owner_last || (burst_next == BURST_W'(MAX_BURST));
  assign timeout_hit = (idle_next == IDLE_W'(TIMEOUT));

  // Arbitration FSM: stalls (valid high but no write) advance no counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      grant     <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      rr_last   <= IDXW'(NREQ - 1);
    end else if (state == ARB) begin
      if (pick_hit) begin
        grant     <= pick_onehot;
        rr_last   <= pick_idx;
        burst_cnt <= '0;
        idle_cnt  <= '0;
        state     <= OWN;
      end
    end else begin
      if (fifo_write_en) begin
        burst_cnt <= burst_next;
        idle_cnt  <= '0;
        if (last_beat) begin
          state <= ARB;
          grant <= '0;
        end
      end else if (!owner_valid) begin
        idle_cnt <= idle_next;
        if (timeout_hit) begin
          state <= ARB;
          grant <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DWIDTH=4, MAX_BURST=4,
// TIMEOUT=8) with a small 16-deep behavioural FIFO on the write side.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        fifo_write_en;
  logic [3:0]  fifo_data_in;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_read_en;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ      (4),
    .DWIDTH    (4),
    .MAX_BURST (4),
    .TIMEOUT   (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_read_en  (fifo_read_en)
  );

  // Behavioural FIFO: a read takes priority and drops a same-cycle write.
  logic       fifo_clr;
  logic [3:0] mem [16];
  logic [4:0] cnt;
  logic [3:0] wp, rp;

  assign fifo_full  = (cnt == 5'd16);
  assign fifo_empty = (cnt == 5'd0);

  always @(posedge clk) begin
    if (fifo_clr) begin
      cnt <= '0;
      wp  <= '0;
      rp  <= '0;
    end else if (fifo_read_en && cnt != 0) begin
      rp  <= rp + 1'b1;
      cnt <= cnt - 1'b1;
    end else if (fifo_write_en && cnt != 16) begin
      mem[wp] <= fifo_data_in;
      wp      <= wp + 1'b1;
      cnt     <= cnt + 1'b1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 4'h0;
    req_last     = 4'h0;
    req_data     = 16'h0;
    fifo_read_en = 1'b0;
    fifo_clr     = 1'b1;
    tick;
    tick;

    // Reset state, even with every requester valid
    req_valid = 4'hF;
    req_data  = 16'h4321;
    #1;
    check("rst_grant", grant, 4'h0);
    check("rst_wen",   fifo_write_en, 1'b0);
    check("rst_ready", req_ready, 4'h0);
    check("rst_data",  fifo_data_in, 4'h0);
    tick;
    rst_n    = 1'b1;
    fifo_clr = 1'b0;

    // Round-robin, no last: 0,1,2,3 with 4 beats each and a dead ARB cycle
    for (int r = 0; r < 4; r++) begin
      #1;
      check("rr_arb_grant", grant, 4'h0);
      check("rr_arb_wen",   fifo_write_en, 1'b0);
      tick;
      for (int b = 0; b < 4; b++) begin
        #1;
        check("rr_grant", grant, 32'(1 << r));
        check("rr_wen",   fifo_write_en, 1'b1);
        check("rr_data",  fifo_data_in, 32'(r + 1));
        check("rr_ready", req_ready, 32'(1 << r));
        check("rr_notfull", fifo_full, 1'b0);
        tick;
      end
    end
    check("rr_full_after16", fifo_full, 1'b1);
    for (int i = 0; i < 16; i++) check("rr_fifo_word", mem[i], 32'(i / 4 + 1));

    // Backpressure: FIFO full, requester 2 alone
    req_valid = 4'b0100;
    #1;
    check("bp_arb_grant", grant, 4'h0);
    tick;
    for (int k = 0; k < 20; k++) begin
      #1;
      check("bp_grant", grant, 4'b0100);
      check("bp_ready", req_ready, 4'h0);
      check("bp_wen",   fifo_write_en, 1'b0);
      tick;
    end
    fifo_read_en = 1'b1;
    #1;
    check("bp_read_nowr", fifo_write_en, 1'b0);
    tick;
    fifo_read_en = 1'b0;
    #1;
    check("bp_after_rd_wen",   fifo_write_en, 1'b1);
    check("bp_after_rd_ready", req_ready, 4'b0100);
    check("bp_after_rd_data",  fifo_data_in, 4'h3);
    tick;

    // Read collision: beat 1 done; three collision cycles must not count
    fifo_read_en = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("col_wen",   fifo_write_en, 1'b0);
      check("col_ready", req_ready, 4'h0);
      check("col_grant", grant, 4'b0100);
      tick;
    end
    fifo_read_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("col_beat_grant", grant, 4'b0100);
      check("col_beat_wen",   fifo_write_en, 1'b1);
      tick;
    end
    #1;
    check("col_release", grant, 4'h0);
    req_valid = 4'h0;
    fifo_clr  = 1'b1;
    tick;
    fifo_clr  = 1'b0;

    // Short burst: req1 sends A then B with last; req0 valid is ignored
    req_valid = 4'b0010;
    req_data  = 16'h00A0;
    req_last  = 4'h0;
    #1;
    check("sb_arb_grant", grant, 4'h0);
    tick;
    req_valid = 4'b0011;
    #1;
    check("sb_grant", grant, 4'b0010);
    check("sb_ready_a", req_ready, 4'b0010);
    check("sb_data_a",  fifo_data_in, 4'hA);
    tick;
    req_data = 16'h00B0;
    req_last = 4'b0010;
    #1;
    check("sb_ready_b", req_ready, 4'b0010);
    check("sb_data_b",  fifo_data_in, 4'hB);
    tick;
    req_valid = 4'h0;
    req_last  = 4'h0;
    #1;
    check("sb_release", grant, 4'h0);
    check("sb_fifo_cnt", cnt, 5'd2);
    check("sb_fifo_0", mem[0], 4'hA);
    check("sb_fifo_1", mem[1], 4'hB);

    // Timeout: req3 granted then idle; req0 waits meanwhile
    req_valid = 4'b1000;
    req_data  = 16'h4321;
    tick;
    req_valid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("to_hold_grant", grant, 4'b1000);
      check("to_hold_wen",   fifo_write_en, 1'b0);
      tick;
    end
    #1;
    check("to_released", grant, 4'h0);
    tick;
    #1;
    check("to_next_grant", grant, 4'b0001);

    // Reset mid-burst: grant drops at once; next winner is requester 0
    check("rm_wen", fifo_write_en, 1'b1);
    tick;
    req_valid = 4'hF;
    rst_n     = 1'b0;
    #1;
    check("rm_grant", grant, 4'h0);
    check("rm_wen0",  fifo_write_en, 1'b0);
    check("rm_ready", req_ready, 4'h0);
    tick;
    rst_n = 1'b1;
    #1;
    check("rm_arb_grant", grant, 4'h0);
    tick;
    #1;
    check("rm_first_grant", grant, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
